// File: rtl/warp_scheduler_pkg.sv
// Shared types and helpers for the per-core warp scheduler.
package warp_scheduler_pkg;

  // Lifecycle of one warp inside the scheduler (separate from warp_state_t).
  typedef enum logic [2:0] {
    SW_IDLE  = 3'd0,
    SW_FETCH = 3'd1,
    SW_READY = 3'd2,
    SW_EXEC  = 3'd3,
    SW_DONE  = 3'd4
  } sched_warp_state_t;

  // Widest execution mask the helper can build; callers truncate to their width.
  localparam int MAX_THREADS = 64;

  // Mask for the last launched warp: low 'tail' bits set, or all 't' bits when tail is 0
  // (or larger than the warp).
  function automatic logic [MAX_THREADS-1:0] tail_mask(input int tail, input int t);
    logic [MAX_THREADS-1:0] m;
    m = {MAX_THREADS{1'b0}};
    for (int i = 0; i < MAX_THREADS; i++) begin
      if ((i < t) && ((tail == 0) || (i < tail))) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer, wrapping around.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any_valid
);

  logic [IW-1:0] cand_s;

  // Scan from the pointer upward with wrap; the first requester wins.
  always_comb begin
    grant_oh  = {N{1'b0}};
    grant_idx = {IW{1'b0}};
    any_valid = 1'b0;
    cand_s    = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = IW'((int'(ptr) + i) % N);
      if (!any_valid && req[cand_s]) begin
        any_valid        = 1'b1;
        grant_idx        = cand_s;
        grant_oh[cand_s] = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: per-warp lifecycle, fetch requests, round-robin issue
// of one READY warp at a time, execution-mask tracking and core-level done.
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int WARPS_PER_CORE   = 4,
  parameter int THREADS_PER_WARP = 8,
  localparam int NW_W   = $clog2(WARPS_PER_CORE + 1),
  localparam int IDX_W  = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1,
  localparam int TAIL_W = $clog2(THREADS_PER_WARP + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NW_W-1:0]             num_warps,
  input  logic [TAIL_W-1:0]           tail_threads,
  output logic                        busy,
  output logic                        done,
  output logic [WARPS_PER_CORE-1:0]   fetch_req,
  input  logic [WARPS_PER_CORE-1:0]   fetch_resp_valid,
  output logic                        issue_valid,
  output logic [IDX_W-1:0]            issue_warp,
  output logic [THREADS_PER_WARP-1:0] issue_mask,
  input  logic                        issue_ready,
  input  logic                        exec_done,
  input  logic                        exec_finish,
  input  logic                        mask_we,
  input  logic [THREADS_PER_WARP-1:0] mask_wdata
);

  localparam int W = WARPS_PER_CORE;
  localparam int T = THREADS_PER_WARP;

  sched_warp_state_t state_r     [W];
  sched_warp_state_t state_nxt_s [W];
  logic [T-1:0]      mask_r      [W];
  logic [T-1:0]      mask_nxt_s  [W];

  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  exec_warp_r;
  logic              exec_busy_r;
  logic              busy_r;
  logic              done_r;
  logic [W-1:0]      fetch_req_r;

  logic              launch_s;
  logic [NW_W-1:0]   n_clamp_s;
  logic [T-1:0]      tail_mask_s;
  logic [W-1:0]      req_s;
  logic [W-1:0]      arb_oh_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic              arb_any_s;
  logic              issue_fire_s;
  logic              exec_retire_s;
  logic              all_done_nxt_s;
  logic [T-1:0]      sel_mask_s;
  logic [IDX_W-1:0]  rr_ptr_nxt_s;

  // Launch decode: clamp the requested warp count and build the tail mask.
  always_comb begin
    launch_s    = start && !busy_r;
    n_clamp_s   = (num_warps > NW_W'(W)) ? NW_W'(W) : num_warps;
    tail_mask_s = T'(tail_mask(int'(tail_threads), T));
  end

  // READY warps request the shared execute path.
  always_comb begin
    req_s = {W{1'b0}};
    for (int w = 0; w < W; w++) begin
      req_s[w] = (state_r[w] == SW_READY);
    end
  end

  rr_arbiter #(.N(W)) u_arb (
    .req       (req_s),
    .ptr       (rr_ptr_r),
    .grant_oh  (arb_oh_s),
    .grant_idx (arb_idx_s),
    .any_valid (arb_any_s)
  );

  // Mask of the granted warp, selected through the one-hot grant.
  always_comb begin
    sel_mask_s = {T{1'b0}};
    for (int w = 0; w < W; w++) begin
      if (arb_oh_s[w]) begin
        sel_mask_s = sel_mask_s | mask_r[w];
      end else begin
        sel_mask_s = sel_mask_s;
      end
    end
  end

  // Issue is gated by the registered exec_busy, which also yields the bubble after exec_done.
  assign issue_valid   = arb_any_s && !exec_busy_r;
  assign issue_warp    = issue_valid ? arb_idx_s : {IDX_W{1'b0}};
  assign issue_mask    = issue_valid ? sel_mask_s : {T{1'b0}};
  assign issue_fire_s  = issue_valid && issue_ready;
  assign exec_retire_s = exec_done && exec_busy_r;

  // Pointer moves to the slot just after the warp that was issued.
  always_comb begin
    if (arb_idx_s == IDX_W'(W - 1)) begin
      rr_ptr_nxt_s = {IDX_W{1'b0}};
    end else begin
      rr_ptr_nxt_s = arb_idx_s + IDX_W'(1);
    end
  end

  // Next state and mask of every warp.
  always_comb begin
    for (int w = 0; w < W; w++) begin
      state_nxt_s[w] = state_r[w];
      mask_nxt_s[w]  = mask_r[w];
    end
    if (launch_s) begin
      for (int w = 0; w < W; w++) begin
        if (NW_W'(w) < n_clamp_s) begin
          state_nxt_s[w] = SW_FETCH;
          mask_nxt_s[w]  = (NW_W'(w + 1) == n_clamp_s) ? tail_mask_s : {T{1'b1}};
        end else begin
          state_nxt_s[w] = SW_IDLE;
          mask_nxt_s[w]  = {T{1'b0}};
        end
      end
    end else begin
      for (int w = 0; w < W; w++) begin
        case (state_r[w])
          SW_FETCH: begin
            if (fetch_resp_valid[w]) begin
              state_nxt_s[w] = SW_READY;
            end else begin
              state_nxt_s[w] = SW_FETCH;
            end
          end
          SW_READY: begin
            if (issue_fire_s && (arb_idx_s == IDX_W'(w))) begin
              state_nxt_s[w] = SW_EXEC;
            end else begin
              state_nxt_s[w] = SW_READY;
            end
          end
          SW_EXEC: begin
            if (exec_retire_s && (exec_warp_r == IDX_W'(w))) begin
              if (mask_we) begin
                mask_nxt_s[w] = mask_wdata;
              end else begin
                mask_nxt_s[w] = mask_r[w];
              end
              if (exec_finish || (mask_we && ~|mask_wdata)) begin
                state_nxt_s[w] = SW_DONE;
              end else begin
                state_nxt_s[w] = SW_FETCH;
              end
            end else begin
              state_nxt_s[w] = SW_EXEC;
            end
          end
          default: begin
            state_nxt_s[w] = state_r[w];
          end
        endcase
      end
    end
  end

  // Completion is judged on the next state so done rises together with the last DONE.
  always_comb begin
    all_done_nxt_s = 1'b1;
    for (int w = 0; w < W; w++) begin
      if ((state_nxt_s[w] != SW_DONE) && (state_nxt_s[w] != SW_IDLE)) begin
        all_done_nxt_s = 1'b0;
      end else begin
        all_done_nxt_s = all_done_nxt_s;
      end
    end
  end

  // Per-warp state, masks and registered fetch requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < W; w++) begin
        state_r[w]     <= SW_IDLE;
        mask_r[w]      <= {T{1'b0}};
        fetch_req_r[w] <= 1'b0;
      end
    end else begin
      for (int w = 0; w < W; w++) begin
        state_r[w]     <= state_nxt_s[w];
        mask_r[w]      <= mask_nxt_s[w];
        fetch_req_r[w] <= (state_nxt_s[w] == SW_FETCH);
      end
    end
  end

  // Execute-path occupancy and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_busy_r <= 1'b0;
      exec_warp_r <= {IDX_W{1'b0}};
      rr_ptr_r    <= {IDX_W{1'b0}};
    end else if (issue_fire_s) begin
      exec_busy_r <= 1'b1;
      exec_warp_r <= arb_idx_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
    end else if (exec_retire_s) begin
      exec_busy_r <= 1'b0;
    end else begin
      exec_busy_r <= exec_busy_r;
    end
  end

  // Core-level busy/done: set on launch, released when every launched warp is DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (launch_s) begin
      busy_r <= (n_clamp_s != {NW_W{1'b0}});
      done_r <= (n_clamp_s == {NW_W{1'b0}});
    end else if (busy_r && all_done_nxt_s) begin
      busy_r <= 1'b0;
      done_r <= 1'b1;
    end else begin
      busy_r <= busy_r;
      done_r <= done_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign fetch_req = fetch_req_r;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed scoreboard bench for warp_scheduler (4 warps, 8 threads).
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] num_warps;
  logic [3:0] tail_threads;
  logic       busy;
  logic       done;
  logic [3:0] fetch_req;
  logic [3:0] fetch_resp_valid;
  logic       issue_valid;
  logic [1:0] issue_warp;
  logic [7:0] issue_mask;
  logic       issue_ready;
  logic       exec_done;
  logic       exec_finish;
  logic       mask_we;
  logic [7:0] mask_wdata;

  typedef struct {
    int         warp;
    logic [7:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  warp_scheduler #(.WARPS_PER_CORE(4), .THREADS_PER_WARP(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_warps        (num_warps),
    .tail_threads     (tail_threads),
    .busy             (busy),
    .done             (done),
    .fetch_req        (fetch_req),
    .fetch_resp_valid (fetch_resp_valid),
    .issue_valid      (issue_valid),
    .issue_warp       (issue_warp),
    .issue_mask       (issue_mask),
    .issue_ready      (issue_ready),
    .exec_done        (exec_done),
    .exec_finish      (exec_finish),
    .mask_we          (mask_we),
    .mask_wdata       (mask_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int w, input logic [7:0] m);
    exp_t e;
    e.warp = w;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic pulse_fetch(input logic [3:0] v);
    fetch_resp_valid = v;
    tick();
    fetch_resp_valid = 4'b0000;
  endtask

  task automatic do_start(input logic [2:0] n, input logic [3:0] tail);
    start        = 1'b1;
    num_warps    = n;
    tail_threads = tail;
    tick();
    start        = 1'b0;
  endtask

  // Wait for an offer, compare against the scoreboard, check it holds, then accept it.
  task automatic offer_and_accept(output int w);
    exp_t e;
    int   n;
    n = 0;
    while ((issue_valid !== 1'b1) && (n < 64)) begin
      tick();
      n++;
    end
    check("offer_valid", 32'(issue_valid), 32'd1);
    check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.warp = 0;
      e.mask = 8'h00;
    end
    check("issue_warp", 32'(issue_warp), 32'(e.warp));
    check("issue_mask", 32'(issue_mask), 32'(e.mask));
    tick();
    check("hold_warp", 32'(issue_warp), 32'(e.warp));
    check("hold_mask", 32'(issue_mask), 32'(e.mask));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("no_issue_while_exec", 32'(issue_valid), 32'd0);
    w = e.warp;
  endtask

  // Retire the in-flight warp; refetch it unless it finished.
  task automatic retire(input int w, input logic fin, input logic we, input logic [7:0] wd);
    exec_done   = 1'b1;
    exec_finish = fin;
    mask_we     = we;
    mask_wdata  = wd;
    tick();
    exec_done   = 1'b0;
    exec_finish = 1'b0;
    mask_we     = 1'b0;
    mask_wdata  = 8'h00;
    if (fin || (we && (wd == 8'h00))) begin
      check("no_refetch", 32'(fetch_req[w]), 32'd0);
    end else begin
      check("refetch", 32'(fetch_req[w]), 32'd1);
      pulse_fetch(4'(4'b0001 << w));
    end
  endtask

  task automatic issue_one(input logic fin, input logic we, input logic [7:0] wd);
    int w;
    offer_and_accept(w);
    retire(w, fin, we, wd);
  endtask

  initial begin
    int w;
    reset = 1'b1; start = 1'b0; num_warps = 3'd0; tail_threads = 4'd0;
    fetch_resp_valid = 4'b0000; issue_ready = 1'b0; exec_done = 1'b0;
    exec_finish = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_warp", 32'(issue_warp), 32'd0);
    check("rst_issue_mask", 32'(issue_mask), 32'd0);
    reset = 1'b0;
    tick();

    // Three warps, tail of 5 threads.
    do_start(3'd3, 4'd5);
    check("launch3_fetch_req", 32'(fetch_req), 32'h7);
    check("launch3_busy", 32'(busy), 32'd1);
    check("launch3_done", 32'(done), 32'd0);
    pulse_fetch(4'b1111);
    check("ready_fetch_req", 32'(fetch_req), 32'h0);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 8'hFF);
      push_exp(1, 8'hFF);
      push_exp(2, 8'h1F);
      for (int k = 0; k < 3; k++) issue_one(1'b0, 1'b0, 8'h00);
    end
    // Divergence update, then finishes, then mask collapse to zero.
    push_exp(0, 8'hFF); issue_one(1'b0, 1'b1, 8'h0C);
    push_exp(1, 8'hFF); issue_one(1'b1, 1'b0, 8'h00);
    push_exp(2, 8'h1F); issue_one(1'b1, 1'b0, 8'h00);
    push_exp(0, 8'h0C); issue_one(1'b0, 1'b1, 8'h00);
    check("run1_done", 32'(done), 32'd1);
    check("run1_busy", 32'(busy), 32'd0);
    tick(); tick();
    check("run1_done_hold", 32'(done), 32'd1);
    check("run1_no_reissue", 32'(issue_valid), 32'd0);

    // Four full warps: pointer wrap with only warps 1 and 3 ready.
    do_start(3'd4, 4'd0);
    check("launch4_done_clr", 32'(done), 32'd0);
    check("launch4_busy", 32'(busy), 32'd1);
    check("launch4_fetch_req", 32'(fetch_req), 32'hF);
    pulse_fetch(4'b0010);
    push_exp(1, 8'hFF); issue_one(1'b0, 1'b0, 8'h00);
    pulse_fetch(4'b1000);
    push_exp(3, 8'hFF); issue_one(1'b1, 1'b0, 8'h00);
    push_exp(1, 8'hFF); issue_one(1'b1, 1'b0, 8'h00);
    pulse_fetch(4'b0101);
    push_exp(2, 8'hFF); issue_one(1'b1, 1'b0, 8'h00);
    check("run2_not_done_yet", 32'(done), 32'd0);
    push_exp(0, 8'hFF); issue_one(1'b1, 1'b0, 8'h00);
    check("run2_done", 32'(done), 32'd1);
    check("run2_busy", 32'(busy), 32'd0);
    tick(); tick(); tick();
    check("run2_done_hold", 32'(done), 32'd1);

    // Reset while a warp is executing, then stray responses.
    do_start(3'd2, 4'd3);
    check("launch2_fetch_req", 32'(fetch_req), 32'h3);
    check("launch2_done_clr", 32'(done), 32'd0);
    pulse_fetch(4'b0011);
    push_exp(1, 8'h07);
    offer_and_accept(w);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_fetch_req", 32'(fetch_req), 32'd0);
    check("midrst_issue_valid", 32'(issue_valid), 32'd0);
    check("midrst_issue_warp", 32'(issue_warp), 32'd0);
    check("midrst_issue_mask", 32'(issue_mask), 32'd0);
    exec_done = 1'b1; exec_finish = 1'b1; fetch_resp_valid = 4'b1111;
    tick();
    exec_done = 1'b0; exec_finish = 1'b0; fetch_resp_valid = 4'b0000;
    tick();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_done", 32'(done), 32'd0);
    check("stray_fetch_req", 32'(fetch_req), 32'd0);
    check("stray_issue_valid", 32'(issue_valid), 32'd0);

    // Zero-warp launch completes immediately.
    do_start(3'd0, 4'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_fetch_req", 32'(fetch_req), 32'd0);

    // Oversized launch clamps to four warps; last warp gets a 2-thread mask.
    do_start(3'd7, 4'd2);
    check("clamp_fetch_req", 32'(fetch_req), 32'hF);
    check("clamp_busy", 32'(busy), 32'd1);
    check("clamp_done", 32'(done), 32'd0);
    do_start(3'd1, 4'd0);
    check("ignored_start_fetch_req", 32'(fetch_req), 32'hF);
    pulse_fetch(4'b1000);
    push_exp(3, 8'h03); issue_one(1'b1, 1'b0, 8'h00);
    check("clamp_still_busy", 32'(busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
